membus_lsu: RTL and testbench

- Load/store initiator that drives the Membus master side toward memory-mapped slaves (ACLINT, RAM, etc.).
- Accepts one core load/store request at a time and converts size and offset into a byte wmask with lane-shifted wdata.
- Issues the transaction and waits for the slave's rvalid.
- Returns lane-extracted, sign- or zero-extended load data to the core as a one-cycle response.

---
 rtl/membus_lsu_if.sv | 24 ++
 rtl/membus_lsu.sv | 195 +++++++++++++++++++
 tb/tb_membus_lsu.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/membus_lsu_if.sv
// rtl/membus_lsu_if.sv - Membus request/response bundle between the LSU and memory-mapped slaves
interface Membus #(
    parameter int XLEN       = 64,
    parameter int DATA_WIDTH = 64
);
    logic                    valid;
    logic                    ready;
    logic [XLEN-1:0]         addr;
    logic                    wen;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wmask;
    logic                    rvalid;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output valid, addr, wen, wdata, wmask,
        input  ready, rvalid, rdata
    );

    modport slave (
        input  valid, addr, wen, wdata, wmask,
        output ready, rvalid, rdata
    );
endinterface

// File: rtl/membus_lsu.sv
// rtl/membus_lsu.sv - load/store initiator on Membus; MEMBUS_LSU_MISALIGN_CHECK_EN enables misaligned-access faulting
module membus_lsu #(
    parameter int XLEN       = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [XLEN-1:0]       req_addr,
    input  logic                  req_wen,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_fault,
    Membus.master                 membus
);
    localparam int MW = DATA_WIDTH / 8;
    localparam int OW = $clog2(MW);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
`ifdef MEMBUS_LSU_MISALIGN_CHECK_EN
        ,
        FAULT     = 2'd3
`endif
    } state_t;

    state_t                state_q, state_n;
    logic [OW-1:0]         off_q, off_n;
    logic [1:0]            size_q, size_n;
    logic                  uns_q, uns_n;
    logic                  mvalid_q, mvalid_n;
    logic [XLEN-1:0]       maddr_q, maddr_n;
    logic                  mwen_q, mwen_n;
    logic [DATA_WIDTH-1:0] mwdata_q, mwdata_n;
    logic [MW-1:0]         mwmask_q, mwmask_n;
    logic                  rvld_q, rvld_n;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_n;
    logic                  fault_q, fault_n;

    logic [MW-1:0]         base_mask;
    logic [DATA_WIDTH-1:0] rshift;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  misaligned;

    always_comb begin
        base_mask = '0;
        case (req_size)
            2'd0:    base_mask = MW'(8'h01);
            2'd1:    base_mask = MW'(8'h03);
            2'd2:    base_mask = MW'(8'h0F);
            default: base_mask = MW'(8'hFF);
        endcase
    end

`ifdef MEMBUS_LSU_MISALIGN_CHECK_EN
    logic [OW-1:0] low_bits;
    always_comb begin
        low_bits = '0;
        case (req_size)
            2'd0:    low_bits = OW'(0);
            2'd1:    low_bits = OW'(1);
            2'd2:    low_bits = OW'(3);
            default: low_bits = OW'(7);
        endcase
        misaligned = |(req_addr[OW-1:0] & low_bits);
    end
`else
    assign misaligned = 1'b0;
`endif

    // Lane extraction works on the latched offset/size, since the request bus may already carry the next access.
    always_comb begin
        rshift   = membus.rdata >> {off_q, 3'b000};
        load_ext = '0;
        case (size_q)
            2'd0: load_ext = uns_q ? DATA_WIDTH'(rshift[7:0])
                                   : {{(DATA_WIDTH-8){rshift[7]}}, rshift[7:0]};
            2'd1: load_ext = uns_q ? DATA_WIDTH'(rshift[15:0])
                                   : {{(DATA_WIDTH-16){rshift[15]}}, rshift[15:0]};
            2'd2: load_ext = uns_q ? DATA_WIDTH'(rshift[31:0])
                                   : {{(DATA_WIDTH-32){rshift[31]}}, rshift[31:0]};
            default: load_ext = rshift;
        endcase
    end

    always_comb begin
        state_n   = state_q;
        off_n     = off_q;
        size_n    = size_q;
        uns_n     = uns_q;
        mvalid_n  = mvalid_q;
        maddr_n   = maddr_q;
        mwen_n    = mwen_q;
        mwdata_n  = mwdata_q;
        mwmask_n  = mwmask_q;
        rvld_n    = 1'b0;
        rdata_n   = '0;
        fault_n   = 1'b0;
        req_ready = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_n  = req_addr[OW-1:0];
                    size_n = req_size;
                    uns_n  = req_unsigned;
`ifdef MEMBUS_LSU_MISALIGN_CHECK_EN
                    if (misaligned) begin
                        state_n = FAULT;
                    end else
`endif
                    begin
                        mvalid_n = 1'b1;
                        maddr_n  = req_addr;
                        mwen_n   = req_wen;
                        mwdata_n = req_wdata << {req_addr[OW-1:0], 3'b000};
                        mwmask_n = base_mask << req_addr[OW-1:0];
                        state_n  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (membus.ready) begin
                    mvalid_n = 1'b0;
                    state_n  = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (membus.rvalid) begin
                    rvld_n  = 1'b1;
                    rdata_n = mwen_q ? '0 : load_ext;
                    state_n = IDLE;
                end
            end
`ifdef MEMBUS_LSU_MISALIGN_CHECK_EN
            FAULT: begin
                rvld_n  = 1'b1;
                fault_n = 1'b1;
                state_n = IDLE;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            mvalid_q <= 1'b0;
            maddr_q  <= '0;
            mwen_q   <= 1'b0;
            mwdata_q <= '0;
            mwmask_q <= '0;
            rvld_q   <= 1'b0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            off_q    <= off_n;
            size_q   <= size_n;
            uns_q    <= uns_n;
            mvalid_q <= mvalid_n;
            maddr_q  <= maddr_n;
            mwen_q   <= mwen_n;
            mwdata_q <= mwdata_n;
            mwmask_q <= mwmask_n;
            rvld_q   <= rvld_n;
            rdata_q  <= rdata_n;
            fault_q  <= fault_n;
        end
    end

    assign membus.valid = mvalid_q;
    assign membus.addr  = maddr_q;
    assign membus.wen   = mwen_q;
    assign membus.wdata = mwdata_q;
    assign membus.wmask = mwmask_q;
    assign resp_valid   = rvld_q;
    assign resp_rdata   = rdata_q;
`ifdef MEMBUS_LSU_MISALIGN_CHECK_EN
    assign resp_fault   = fault_q;
`else
    assign resp_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_membus_lsu.sv
// tb/tb_membus_lsu.sv - directed scoreboard bench for membus_lsu
module tb_membus_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_wen;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_fault;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];

    Membus #(.XLEN(64), .DATA_WIDTH(64)) mb ();

    membus_lsu #(.XLEN(64), .DATA_WIDTH(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_wen      (req_wen),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .membus       (mb)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic txn(input string tag, input logic [63:0] addr, input logic wen,
                       input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                       input logic [63:0] rdata, input logic [7:0] exp_wmask,
                       input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                       input int stall, input logic spurious);
        int lat;
        logic [63:0] exp;
        chk({tag, " req_ready"}, 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_addr     = addr;
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        mb.ready     = (stall == 0);
        mb.rvalid    = 1'b0;
        sb.push_back(exp_rdata);
        step();
        req_valid = 1'b0;
        chk({tag, " valid"}, 64'(mb.valid), 64'd1);
        chk({tag, " addr"}, mb.addr, addr);
        chk({tag, " wen"}, 64'(mb.wen), 64'(wen));
        chk({tag, " wdata"}, mb.wdata, exp_wdata);
        chk({tag, " wmask"}, 64'(mb.wmask), 64'(exp_wmask));
        chk({tag, " busy"}, 64'(req_ready), 64'd0);
        for (int d = 0; d < stall; d++) begin
            mb.rvalid = spurious && (d == 0);
            mb.rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
            step();
            chk({tag, " hold valid"}, 64'(mb.valid), 64'd1);
            chk({tag, " hold addr"}, mb.addr, addr);
            chk({tag, " hold wdata"}, mb.wdata, exp_wdata);
            chk({tag, " hold wmask"}, 64'(mb.wmask), 64'(exp_wmask));
            chk({tag, " no early resp"}, 64'(resp_valid), 64'd0);
        end
        mb.ready  = 1'b1;
        mb.rvalid = 1'b0;
        step();
        chk({tag, " valid drop"}, 64'(mb.valid), 64'd0);
        chk({tag, " wait no resp"}, 64'(resp_valid), 64'd0);
        mb.ready  = 1'b0;
        mb.rvalid = 1'b1;
        mb.rdata  = rdata;
        step();
        mb.rvalid = 1'b0;
        mb.rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        lat = 0;
        while (!resp_valid && lat < 4) begin
            step();
            lat++;
        end
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
        chk({tag, " resp latency"}, 64'(lat), 64'd0);
        if (resp_valid && sb.size() > 0) begin
            exp = sb.pop_front();
            chk({tag, " resp_rdata"}, resp_rdata, exp);
            chk({tag, " resp_fault"}, 64'(resp_fault), 64'd0);
        end
    endtask

    initial begin
        rst          = 1'b0;
        req_valid    = 1'b0;
        req_addr     = '0;
        req_wen      = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = '0;
        mb.ready     = 1'b0;
        mb.rvalid    = 1'b0;
        mb.rdata     = '0;
        step();
        step();
        chk("reset valid", 64'(mb.valid), 64'd0);
        chk("reset wmask", 64'(mb.wmask), 64'd0);
        chk("reset addr", mb.addr, 64'd0);
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset resp_rdata", resp_rdata, 64'd0);
        chk("reset resp_fault", 64'(resp_fault), 64'd0);
        rst = 1'b1;
        step();
        chk("idle ready", 64'(req_ready), 64'd1);

        txn("sd", 64'h0200_4000, 1'b1, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'hFFFF_0000_FFFF_0000,
            8'hFF, 64'h1122_3344_5566_7788, 64'd0, 0, 1'b0);
        txn("lb", 64'h0200_4003, 1'b0, 2'd0, 1'b0, 64'd0, 64'h0000_0000_8000_0000,
            8'h08, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 0, 1'b0);
        txn("lbu", 64'h0200_4003, 1'b0, 2'd0, 1'b1, 64'd0, 64'h0000_0000_8000_0000,
            8'h08, 64'd0, 64'h0000_0000_0000_0080, 0, 1'b0);
        txn("sh6", 64'h0200_4006, 1'b1, 2'd1, 1'b0, 64'h0000_0000_0000_ABCD, 64'h1234,
            8'hC0, 64'hABCD_0000_0000_0000, 64'd0, 0, 1'b0);
        txn("lw bp", 64'h0200_4004, 1'b0, 2'd2, 1'b0, 64'd0, 64'h8765_4321_0000_0000,
            8'hF0, 64'd0, 64'hFFFF_FFFF_8765_4321, 3, 1'b1);
        txn("lhu", 64'h0200_4002, 1'b0, 2'd1, 1'b1, 64'd0, 64'h0000_0000_F00D_0000,
            8'h0C, 64'd0, 64'h0000_0000_0000_F00D, 0, 1'b0);
        txn("lh", 64'h0200_4002, 1'b0, 2'd1, 1'b0, 64'd0, 64'h0000_0000_F00D_0000,
            8'h0C, 64'd0, 64'hFFFF_FFFF_FFFF_F00D, 1, 1'b0);
        txn("ld", 64'h0200_4008, 1'b0, 2'd3, 1'b0, 64'd0, 64'hCAFE_F00D_1234_5678,
            8'hFF, 64'd0, 64'hCAFE_F00D_1234_5678, 0, 1'b0);
        txn("sd off4", 64'h0200_4004, 1'b1, 2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'd0,
            8'hF0, 64'h5566_7788_0000_0000, 64'd0, 0, 1'b0);

`ifdef MEMBUS_LSU_MISALIGN_CHECK_EN
        chk("mis req_ready", 64'(req_ready), 64'd1);
        req_valid    = 1'b1;
        req_addr     = 64'h0200_4002;
        req_wen      = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        step();
        req_valid = 1'b0;
        chk("mis no valid", 64'(mb.valid), 64'd0);
        chk("mis no early resp", 64'(resp_valid), 64'd0);
        step();
        chk("mis no valid 2", 64'(mb.valid), 64'd0);
        chk("mis resp_valid", 64'(resp_valid), 64'd1);
        chk("mis resp_fault", 64'(resp_fault), 64'd1);
        chk("mis resp_rdata", resp_rdata, 64'd0);
        step();
        chk("mis pulse end", 64'(resp_valid), 64'd0);
        chk("mis back idle", 64'(req_ready), 64'd1);
`else
        txn("lw mis", 64'h0200_4002, 1'b0, 2'd2, 1'b0, 64'h0000_0000_0000_1234, 64'h0000_4433_2211_0000,
            8'h3C, 64'h0000_0000_1234_0000, 64'h0000_0000_4433_2211, 0, 1'b0);
`endif

        chk("rst pre ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_addr  = 64'h0200_4000;
        req_wen   = 1'b0;
        req_size  = 2'd3;
        mb.ready  = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("rst in wait", 64'(mb.valid), 64'd0);
        #2 rst = 1'b0;
        #1;
        chk("rst async valid", 64'(mb.valid), 64'd0);
        chk("rst async wmask", 64'(mb.wmask), 64'd0);
        chk("rst async addr", mb.addr, 64'd0);
        chk("rst async resp", 64'(resp_valid), 64'd0);
        chk("rst async ready", 64'(req_ready), 64'd1);
        step();
        rst       = 1'b1;
        mb.ready  = 1'b0;
        mb.rvalid = 1'b1;
        mb.rdata  = 64'h5555_5555_5555_5555;
        step();
        mb.rvalid = 1'b0;
        chk("late rvalid resp", 64'(resp_valid), 64'd0);
        step();
        chk("late rvalid resp 2", 64'(resp_valid), 64'd0);
        chk("post rst ready", 64'(req_ready), 64'd1);
        chk("scoreboard empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
